nba_grader_gen: RTL and testbench

Parametrised next-generation grader for the number-baseball accelerator.
- Scores solver guesses against a secret answer with a configurable number of digits and digit width.
- Counts attempts and terminates the round on a correct guess or when the attempt budget is spent.
- Adds question validity checking and an iterative one-digit-per-cycle scorer.
- Sits between the answer source (bench or host) and the solver, using ask and reply valid/ready handshakes.

---
 rtl/nba_grader_gen.sv | 181 ++++++++++++++++++
 tb/tb_nba_grader_gen.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/nba_grader_gen.sv
// Number-baseball grader: latches a secret, scores each accepted guess one digit per cycle,
// and ends the round on a solve or when the attempt budget runs out.
module nba_grader_gen #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int DIGIT_MAX  = 9,
  parameter int MAX_CNT    = 200,
  parameter int CNT_W      = 16,
  parameter int SB_W       = $clog2(NUM_DIGITS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] answer,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] question,
  input  logic                          ask_valid,
  output logic                          ask_ready,
  output logic [SB_W-1:0]               strike,
  output logic [SB_W-1:0]               ball,
  output logic                          invalid,
  output logic                          reply_valid,
  input  logic                          reply_ready,
  output logic                          correct,
  output logic                          give_up,
  output logic [CNT_W-1:0]              cnt
);

  localparam int VEC_W = NUM_DIGITS * DIGIT_W;

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_ASK   = 3'd1;
  localparam logic [2:0] S_SCORE = 3'd2;
  localparam logic [2:0] S_REPLY = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic [DIGIT_W-1:0] digit(input logic [VEC_W-1:0] v, input int i);
    return v[i*DIGIT_W +: DIGIT_W];
  endfunction

  logic [2:0]         state_q,   state_d;
  logic [VEC_W-1:0]   ans_q,     ans_d;
  logic [VEC_W-1:0]   qst_q,     qst_d;
  logic [SB_W-1:0]    idx_q,     idx_d;
  logic [SB_W-1:0]    strike_q,  strike_d;
  logic [SB_W-1:0]    ball_q,    ball_d;
  logic               inv_q,     inv_d;
  logic               correct_q, correct_d;
  logic               give_up_q, give_up_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;

  logic [DIGIT_W-1:0] cur_digit;
  logic               hit_s;
  logic               hit_b;
  logic               bad;
  logic               last;
  logic [SB_W-1:0]    acc_s;
  logic [SB_W-1:0]    acc_b;
  logic               acc_i;

  // Evaluate the question digit selected by idx_q against the latched answer.
  always_comb begin
    cur_digit = '0;
    hit_s     = 1'b0;
    hit_b     = 1'b0;
    bad       = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == SB_W'(i)) cur_digit = digit(qst_q, i);
    end
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (idx_q == SB_W'(j)) begin
        if (cur_digit == digit(ans_q, j)) hit_s = 1'b1;
      end else if (cur_digit == digit(ans_q, j)) begin
        hit_b = 1'b1;
      end
      if ((SB_W'(j) < idx_q) && (digit(qst_q, j) == cur_digit)) bad = 1'b1;
    end
    if (cur_digit > DIGIT_W'(DIGIT_MAX)) bad = 1'b1;
    last  = (idx_q == SB_W'(NUM_DIGITS - 1));
    acc_s = strike_q + SB_W'(hit_s);
    acc_b = ball_q + SB_W'(hit_b && !hit_s);
    acc_i = inv_q | bad;
  end

  always_comb begin
    state_d   = state_q;
    ans_d     = ans_q;
    qst_d     = qst_q;
    idx_d     = idx_q;
    strike_d  = strike_q;
    ball_d    = ball_q;
    inv_d     = inv_q;
    correct_d = correct_q;
    give_up_d = give_up_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_LOAD: begin
        ans_d   = answer;
        state_d = S_ASK;
      end
      S_ASK: begin
        if (ask_valid) begin
          qst_d    = question;
          cnt_d    = (cnt_q == CNT_W'(MAX_CNT)) ? cnt_q : cnt_q + CNT_W'(1);
          strike_d = '0;
          ball_d   = '0;
          inv_d    = 1'b0;
          idx_d    = '0;
          state_d  = S_SCORE;
        end
      end
      S_SCORE: begin
        idx_d = idx_q + SB_W'(1);
        inv_d = acc_i;
        if (last) begin
          // An illegal question reports no strikes or balls; correct rises with reply_valid.
          strike_d  = acc_i ? '0 : acc_s;
          ball_d    = acc_i ? '0 : acc_b;
          correct_d = !acc_i && (acc_s == SB_W'(NUM_DIGITS));
          state_d   = S_REPLY;
        end else begin
          strike_d = acc_s;
          ball_d   = acc_b;
        end
      end
      S_REPLY: begin
        if (reply_ready) begin
          if (correct_q) begin
            state_d = S_DONE;
          end else if (cnt_q == CNT_W'(MAX_CNT)) begin
            give_up_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_ASK;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_LOAD;
      strike_q  <= '0;
      ball_q    <= '0;
      inv_q     <= 1'b0;
      correct_q <= 1'b0;
      give_up_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      strike_q  <= strike_d;
      ball_q    <= ball_d;
      inv_q     <= inv_d;
      correct_q <= correct_d;
      give_up_q <= give_up_d;
      cnt_q     <= cnt_d;
    end
  end

  // Datapath registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    ans_q <= ans_d;
    qst_q <= qst_d;
    idx_q <= idx_d;
  end

  assign ask_ready   = (state_q == S_ASK);
  assign reply_valid = (state_q == S_REPLY);
  assign strike      = strike_q;
  assign ball        = ball_q;
  assign invalid     = inv_q;
  assign correct     = correct_q;
  assign give_up     = give_up_q;
  assign cnt         = cnt_q;

endmodule

// File: tb/tb_nba_grader_gen.sv
// Directed bench for nba_grader_gen with a scoreboard of expected replies.
module tb_nba_grader_gen;

  localparam int ND   = 4;
  localparam int MAXC = 3;

  typedef struct packed {
    logic [2:0]  s;
    logic [2:0]  b;
    logic        inv;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] answer = '0;
  logic [15:0] question = '0;
  logic        ask_valid = 1'b0;
  logic        ask_ready;
  logic [2:0]  strike;
  logic [2:0]  ball;
  logic        invalid;
  logic        reply_valid;
  logic        reply_ready = 1'b0;
  logic        correct;
  logic        give_up;
  logic [15:0] cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [15:0] cur_ans = '0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  nba_grader_gen #(.MAX_CNT(MAXC)) u_dut (
    .clk(clk), .reset(reset), .answer(answer), .question(question),
    .ask_valid(ask_valid), .ask_ready(ask_ready), .strike(strike), .ball(ball),
    .invalid(invalid), .reply_valid(reply_valid), .reply_ready(reply_ready),
    .correct(correct), .give_up(give_up), .cnt(cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] q, input int c);
    exp_t e;
    int s, b;
    logic inv;
    logic [3:0] qi;
    s = 0; b = 0; inv = 1'b0;
    for (int i = 0; i < ND; i++) begin
      qi = q[i*4 +: 4];
      if (qi > 4'd9) inv = 1'b1;
      for (int j = 0; j < i; j++) if (q[j*4 +: 4] == qi) inv = 1'b1;
      if (qi == a[i*4 +: 4]) s++;
      else begin
        logic found;
        found = 1'b0;
        for (int j = 0; j < ND; j++) if (j != i && a[j*4 +: 4] == qi) found = 1'b1;
        if (found) b++;
      end
    end
    if (inv) begin s = 0; b = 0; end
    e.s = 3'(s); e.b = 3'(b); e.inv = inv; e.cnt = 16'(c);
    return e;
  endfunction

  task automatic do_reset(input logic [15:0] a);
    reset = 1'b0; answer = a; ask_valid = 1'b0; reply_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_ask_ready", 32'(ask_ready), 32'(0));
    check("rst_reply_valid", 32'(reply_valid), 32'(0));
    check("rst_strike", 32'(strike), 32'(0));
    check("rst_ball", 32'(ball), 32'(0));
    check("rst_invalid", 32'(invalid), 32'(0));
    check("rst_correct", 32'(correct), 32'(0));
    check("rst_give_up", 32'(give_up), 32'(0));
    check("rst_cnt", 32'(cnt), 32'(0));
    sb.delete();
    exp_cnt = 0;
    cur_ans = a;
    reset = 1'b1;
    @(posedge clk); #1;
    check("load_ask_ready", 32'(ask_ready), 32'(1));
    answer = 16'hFFFF;
  endtask

  task automatic send_q(input logic [15:0] q);
    int w;
    w = 0;
    while (ask_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
    check("ask_ready_wait", 32'(ask_ready), 32'(1));
    exp_cnt++;
    sb.push_back(model(cur_ans, q, exp_cnt));
    question = q; ask_valid = 1'b1;
    @(posedge clk); #1;
    ask_valid = 1'b0;
    check("score_ask_ready", 32'(ask_ready), 32'(0));
    check("score_strike_clr", 32'(strike), 32'(0));
    check("score_ball_clr", 32'(ball), 32'(0));
  endtask

  task automatic get_reply(input int hold);
    exp_t e;
    int lat;
    logic exp_corr, exp_done, exp_gu;
    lat = 0;
    while (reply_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("latency", 32'(lat), 32'(ND));
    check("sb_size", 32'(sb.size()), 32'(1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    exp_corr = (e.s == 3'(ND)) && !e.inv;
    check("strike", 32'(strike), 32'(e.s));
    check("ball", 32'(ball), 32'(e.b));
    check("invalid", 32'(invalid), 32'(e.inv));
    check("cnt", 32'(cnt), 32'(e.cnt));
    check("correct", 32'(correct), 32'(exp_corr));
    check("give_up_pre", 32'(give_up), 32'(0));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_reply_valid", 32'(reply_valid), 32'(1));
      check("hold_strike", 32'(strike), 32'(e.s));
      check("hold_ball", 32'(ball), 32'(e.b));
      check("hold_ask_ready", 32'(ask_ready), 32'(0));
    end
    reply_ready = 1'b1;
    @(posedge clk); #1;
    reply_ready = 1'b0;
    exp_done = exp_corr || (e.cnt == 16'(MAXC));
    exp_gu   = !exp_corr && (e.cnt == 16'(MAXC));
    check("post_reply_valid", 32'(reply_valid), 32'(0));
    check("post_ask_ready", 32'(ask_ready), 32'(!exp_done));
    check("post_give_up", 32'(give_up), 32'(exp_gu));
    check("post_correct", 32'(correct), 32'(exp_corr));
    check("post_cnt", 32'(cnt), 32'(e.cnt));
    if (exp_done) begin
      repeat (3) @(posedge clk);
      #1;
      check("done_ask_ready", 32'(ask_ready), 32'(0));
      check("done_reply_valid", 32'(reply_valid), 32'(0));
      check("done_strike", 32'(strike), 32'(e.s));
      check("done_cnt", 32'(cnt), 32'(e.cnt));
      check("done_give_up", 32'(give_up), 32'(exp_gu));
      check("done_correct", 32'(correct), 32'(exp_corr));
    end
  endtask

  initial begin
    // Immediate solve on the first attempt.
    do_reset(16'h1234);
    send_q(16'h1234); get_reply(0);

    // Scoring patterns, backpressure, and budget exhaustion on the third attempt.
    do_reset(16'h1234);
    send_q(16'h4321); get_reply(0);
    send_q(16'h1243); get_reply(10);
    send_q(16'h5678); get_reply(0);

    // Illegal questions still count; a solve on the last attempt beats give_up.
    do_reset(16'h1234);
    send_q(16'h1123); get_reply(0);
    send_q(16'h12A4); get_reply(2);
    send_q(16'h1234); get_reply(0);

    // Reset in the middle of scoring, then a fresh round with a new secret.
    do_reset(16'h1234);
    send_q(16'h5678);
    @(posedge clk); #1;
    do_reset(16'h9876);
    send_q(16'h9876); get_reply(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
